// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-side valid/ready port and redirect.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               f_valid;
  logic               f_ready;
  logic [INSTR_W-1:0] f_instr;
  logic [ADDR_W-1:0]  f_pc;
  logic [ADDR_W-1:0]  f_pc1;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output imem_req, imem_addr, f_valid, f_instr, f_pc, f_pc1,
    input  imem_rvalid, imem_rdata, f_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, f_valid, f_instr, f_pc, f_pc1,
    output imem_rvalid, imem_rdata, f_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem read in flight, buffers {pc, instr} in a small FIFO.
module fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter int unsigned          DEPTH    = 2,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DISCARD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   fpc_q    [DEPTH];
  logic [ADDR_W-1:0]   fpc_d    [DEPTH];
  logic [INSTR_W-1:0]  finstr_q [DEPTH];
  logic [INSTR_W-1:0]  finstr_d [DEPTH];
  logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                push, pop;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fpc_d    = fpc_q;
    finstr_d = finstr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    count_d  = count_q;
    pop      = (count_q != '0) && bus.f_ready;
    push     = (state_q == WAIT) && bus.imem_rvalid;

    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      // An outstanding request must still be drained, so WAIT without its response parks in DISCARD.
      unique case (state_q)
        WAIT, DISCARD: state_d = bus.imem_rvalid ? ISSUE : DISCARD;
        default:       state_d = ISSUE;
      endcase
    end else begin
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      if (push) begin
        fpc_d[wr_q]    = pc_q;
        finstr_d[wr_q] = bus.imem_rdata;
        wr_d           = wr_q + 1'b1;
        pc_d           = pc_q + ADDR_W'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      unique case (state_q)
        ISSUE:   state_d = WAIT;
        WAIT:    if (bus.imem_rvalid) state_d = (count_d < DEPTH_C) ? ISSUE : HOLD;
        HOLD:    if (count_d < DEPTH_C) state_d = ISSUE;
        DISCARD: if (bus.imem_rvalid) state_d = ISSUE;
        default: state_d = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fpc_q[i]    <= '0;
        finstr_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
      fpc_q    <= fpc_d;
      finstr_q <= finstr_d;
    end
  end

  // Request is suppressed while reset is held even though state already reads ISSUE.
  assign bus.imem_req  = rst_n && (state_q == ISSUE) && !bus.redirect;
  assign bus.imem_addr = pc_q;
  assign bus.f_valid   = (count_q != '0);
  assign bus.f_instr   = finstr_q[rd_q];
  assign bus.f_pc      = fpc_q[rd_q];
  assign bus.f_pc1     = fpc_q[rd_q] + ADDR_W'(1);

endmodule
